minimig_ram_sequencer: RTL and testbench

Memory-cycle sequencer placed directly downstream of the bank mapper. It accepts a request carrying the mapper's 8-bit bank select plus a word offset within a 512 KB block, and converts the bank select to a 3-bit physical block index. It then runs a fixed-latency read or write cycle on the synchronous RAM port and returns a one-cycle acknowledge. The block also interleaves periodic refresh cycles and short-circuits unmapped accesses without touching memory.

---
 rtl/minimig_mem_pkg.sv | 22 ++
 rtl/minimig_bank_encoder.sv | 18 +
 rtl/minimig_ram_sequencer.sv | 130 +++++++++++++
 tb/tb_minimig_ram_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minimig_mem_pkg.sv
// Shared definitions for the Minimig RAM sequencer: state encoding,
// block/address widths and the latched request record.
package minimig_mem_pkg;
  localparam int BLK_W  = 3;
  localparam int MEM_AW = 21;
  localparam logic [15:0] UNMAPPED_DATA = 16'hFFFF;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_REFRESH = 3'd4;

  typedef struct packed {
    logic                    we;
    logic                    multi;
    logic [BLK_W-1:0]        blk;
    logic [MEM_AW-BLK_W-1:0] addr;
    logic [1:0]              be;
    logic [15:0]             wdata;
  } mem_req_t;
endpackage

// File: rtl/minimig_bank_encoder.sv
// Bank select to block index: lowest set bit wins, flags empty and multi-hot selects.
module minimig_bank_encoder
  import minimig_mem_pkg::*;
(
  input  logic [7:0]       bank,
  output logic [BLK_W-1:0] blk,
  output logic             hit,
  output logic             multi
);
  always_comb begin
    blk = '0;
    for (int i = 7; i >= 0; i--)
      if (bank[i]) blk = BLK_W'(i);
  end

  assign hit   = |bank;
  assign multi = |(bank & (bank - 8'd1));
endmodule

// File: rtl/minimig_ram_sequencer.sv
// Fixed-latency RAM cycle sequencer with interleaved refresh and
// short-circuit completion of unmapped accesses.
module minimig_ram_sequencer
  import minimig_mem_pkg::*;
#(
  parameter int RD_LAT  = 2,
  parameter int REF_INT = 512,
  parameter int REF_LEN = 4
) (
  input  logic              clk,
  input  logic              _reset,
  input  logic              req,
  input  logic              we,
  input  logic [7:0]        bank,
  input  logic [17:0]       addr,
  input  logic [1:0]        be,
  input  logic [15:0]       wdata,
  output logic              ack,
  output logic [15:0]       rdata,
  output logic              unmapped,
  output logic              bank_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [1:0]        mem_be,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic              mem_ref
);
  logic [2:0]       state;
  logic [BLK_W-1:0] blk;
  logic             hit, multi;
  mem_req_t         r;
  logic [15:0]      ref_cnt;
  logic             ref_pend, ref_wrap;
  logic [3:0]       lat_cnt, len_cnt;

  minimig_bank_encoder u_enc (
    .bank  (bank),
    .blk   (blk),
    .hit   (hit),
    .multi (multi)
  );

  // RAM-side address/data come straight from the latched request flops.
  assign mem_addr  = {r.blk, r.addr};
  assign mem_be    = r.be;
  assign mem_wdata = r.wdata;
  assign ref_wrap  = (ref_cnt == '0);

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) ref_cnt <= 16'(REF_INT - 1);
    else         ref_cnt <= ref_wrap ? 16'(REF_INT - 1) : ref_cnt - 16'd1;
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state    <= S_IDLE;
      r        <= '0;
      ref_pend <= 1'b0;
      lat_cnt  <= '0;
      len_cnt  <= '0;
      ack      <= 1'b0;
      rdata    <= '0;
      unmapped <= 1'b0;
      bank_err <= 1'b0;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      mem_ref  <= 1'b0;
    end else begin
      ack      <= 1'b0;
      unmapped <= 1'b0;
      bank_err <= 1'b0;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ref_pend) begin
            ref_pend <= 1'b0;
            mem_ref  <= 1'b1;
            len_cnt  <= 4'(REF_LEN - 1);
            state    <= S_REFRESH;
          end else if (req && hit) begin
            r      <= '{we: we, multi: multi, blk: blk, addr: addr, be: be, wdata: wdata};
            mem_en <= 1'b1;
            mem_we <= we;
            state  <= S_ISSUE;
          end else if (req) begin
            ack      <= 1'b1;
            unmapped <= 1'b1;
            rdata    <= UNMAPPED_DATA;
            state    <= S_DONE;
          end
        end
        S_ISSUE: begin
          if (r.we) begin
            ack      <= 1'b1;
            bank_err <= r.multi;
            state    <= S_DONE;
          end else begin
            lat_cnt <= 4'(RD_LAT - 1);
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt == '0) begin
            rdata    <= mem_rdata;
            ack      <= 1'b1;
            bank_err <= r.multi;
            state    <= S_DONE;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        S_DONE: state <= S_IDLE;
        S_REFRESH: begin
          if (len_cnt == '0) begin
            mem_ref <= 1'b0;
            state   <= S_IDLE;
          end else begin
            len_cnt <= len_cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
      // A wrap on the same edge as a refresh is taken must stay pending.
      if (ref_wrap) ref_pend <= 1'b1;
    end
  end
endmodule

// File: tb/tb_minimig_ram_sequencer.sv
// Randomized bench for minimig_ram_sequencer against an edge-schedule
// reference model with a small RAM responder.
module tb_minimig_ram_sequencer;
  localparam int RD_LAT  = 2;
  localparam int REF_INT = 64;
  localparam int REF_LEN = 4;

  logic        clk = 1'b0;
  logic        _reset, req, we;
  logic [7:0]  bank;
  logic [17:0] addr;
  logic [1:0]  be;
  logic [15:0] wdata;
  logic        ack, unmapped, bank_err, mem_en, mem_we, mem_ref;
  logic [15:0] rdata, mem_wdata, mem_rdata;
  logic [20:0] mem_addr;
  logic [1:0]  mem_be;

  minimig_ram_sequencer #(.RD_LAT(RD_LAT), .REF_INT(REF_INT), .REF_LEN(REF_LEN)) dut (
    .clk(clk), ._reset(_reset), .req(req), .we(we), .bank(bank), .addr(addr),
    .be(be), .wdata(wdata), .ack(ack), .rdata(rdata), .unmapped(unmapped),
    .bank_err(bank_err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ref(mem_ref)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= _reset ? cyc + 1 : 0;

  function automatic logic [15:0] init_word(int i);
    return 16'(i * 257) ^ 16'h5A5A;
  endfunction

  // RAM responder: data valid RD_LAT cycles after the mem_en cycle, junk otherwise.
  logic [15:0] ram [64];
  logic        ram_clr;
  logic        rd_v = 1'b0;
  logic [5:0]  rd_idx;
  always @(posedge clk) begin
    if (ram_clr) for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
    rd_v   <= mem_en && !mem_we;
    rd_idx <= {mem_addr[20:18], mem_addr[2:0]};
    if (mem_en && mem_we) begin
      if (mem_be[0]) ram[{mem_addr[20:18], mem_addr[2:0]}][7:0]  <= mem_wdata[7:0];
      if (mem_be[1]) ram[{mem_addr[20:18], mem_addr[2:0]}][15:8] <= mem_wdata[15:8];
    end
    mem_rdata <= rd_v ? ram[rd_idx] : 16'($urandom);
  end

  // Reference model: memory contents plus the schedule of refresh windows,
  // expressed as edge numbers counted from reset release.
  logic [15:0] mdl [64];
  int free_edge = 1;
  int serviced = 0;
  int refq[$];

  function automatic int wrap_of(int e);
    return ((e - 1) / REF_INT) * REF_INT;
  endfunction

  function automatic bit pending(int e);
    return wrap_of(e) >= REF_INT && wrap_of(e) > serviced;
  endfunction

  function automatic logic ref_exp(int c);
    foreach (refq[i]) if (c >= refq[i] && c < refq[i] + REF_LEN) return 1'b1;
    return 1'b0;
  endfunction

  task automatic advance(input int c);
    int e = free_edge;
    while (e <= c) begin
      if (pending(e)) begin
        refq.push_back(e); serviced = wrap_of(e); e += REF_LEN + 1;
      end else e++;
    end
    free_edge = e;
  endtask

  task automatic model_start(input int r, output int s);
    int e;
    advance(r - 1);
    e = free_edge;
    while (pending(e)) begin
      refq.push_back(e); serviced = wrap_of(e); e += REF_LEN + 1;
    end
    s = e;
  endtask

  task automatic model_reset();
    free_edge = 1; serviced = 0; refq.delete();
  endtask

  function automatic logic [7:0] rand_bank();
    case ($urandom_range(0, 9))
      0:       return 8'h00;
      1, 2:    return 8'($urandom);
      default: return 8'(32'd1 << $urandom_range(0, 7));
    endcase
  endfunction

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      advance(cyc);
      n_cmp++;
      if ({ack, mem_en, mem_ref} !== {2'b00, ref_exp(cyc)}) begin
        n_err++;
        $display("FAIL idle cyc %0d: ack/mem_en/mem_ref got %b expected %b", cyc,
                 {ack, mem_en, mem_ref}, {2'b00, ref_exp(cyc)});
      end
    end
  endtask

  // Called at a negedge; request becomes visible on the next rising edge.
  task automatic do_txn(input logic t_we, input logic [7:0] t_bank, input logic [17:0] t_addr,
                        input logic [1:0] t_be, input logic [15:0] t_wdata, output int ack_at);
    int s, a, blkv, nset, idx;
    logic [15:0] exp_rd;
    logic [20:0] exp_addr;
    logic [2:0]  b3;
    bit got;
    req = 1'b1; we = t_we; bank = t_bank; addr = t_addr; be = t_be; wdata = t_wdata;
    model_start(cyc + 1, s);
    nset = $countones(t_bank);
    blkv = 0;
    for (int i = 7; i >= 0; i--) if (t_bank[i]) blkv = i;
    b3 = 3'(blkv);
    exp_addr = {b3, t_addr};
    idx = blkv * 8 + int'(t_addr[2:0]);
    exp_rd = 16'h0000;
    if (nset == 0) begin a = s; exp_rd = 16'hFFFF; end
    else if (t_we) a = s + 1;
    else begin a = s + RD_LAT + 1; exp_rd = mdl[idx]; end
    got = 0; ack_at = -1;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      n_cmp++;
      if (mem_ref !== ref_exp(cyc)) begin
        n_err++; $display("FAIL mem_ref cyc %0d: got %b expected %b", cyc, mem_ref, ref_exp(cyc));
      end
      n_cmp++;
      if (mem_en !== (nset != 0 && cyc == s)) begin
        n_err++; $display("FAIL mem_en cyc %0d: got %b expected %b", cyc, mem_en, (nset != 0 && cyc == s));
      end
      if (mem_en) begin
        n_cmp++;
        if ({mem_we, mem_addr, mem_be} !== {t_we, exp_addr, t_be}) begin
          n_err++; $display("FAIL mem_cmd: we/addr/be got %b/%h/%b expected %b/%h/%b",
                            mem_we, mem_addr, mem_be, t_we, exp_addr, t_be);
        end
        if (t_we) begin
          n_cmp++;
          if (mem_wdata !== t_wdata) begin
            n_err++; $display("FAIL mem_wdata: got %h expected %h", mem_wdata, t_wdata);
          end
        end
      end
      if (ack) begin got = 1; ack_at = cyc; end
    end
    req = 1'b0;
    n_cmp++;
    if (!got) begin
      n_err++; $display("FAIL ack_timeout: no ack, expected at cyc %0d", a);
    end else begin
      if (ack_at !== a) begin
        n_err++; $display("FAIL ack_cycle: got %0d expected %0d", ack_at, a);
      end
      n_cmp++;
      if ({unmapped, bank_err} !== {nset == 0, nset > 1}) begin
        n_err++; $display("FAIL flags: unmapped/bank_err got %b expected %b",
                          {unmapped, bank_err}, {nset == 0, nset > 1});
      end
      if (!(t_we && nset != 0)) begin
        n_cmp++;
        if (rdata !== exp_rd) begin
          n_err++; $display("FAIL rdata: got %h expected %h", rdata, exp_rd);
        end
      end
    end
    if (t_we && nset != 0) begin
      if (t_be[0]) mdl[idx][7:0]  = t_wdata[7:0];
      if (t_be[1]) mdl[idx][15:8] = t_wdata[15:8];
    end
    free_edge = a + 2;
    @(negedge clk);
    n_cmp++;
    if (ack !== 1'b0) begin
      n_err++; $display("FAIL ack_pulse: ack still %b one cycle after completion", ack);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ack, unmapped, bank_err, mem_en, mem_we, mem_ref, rdata, mem_addr, mem_be, mem_wdata} !== '0) begin
      n_err++; $display("FAIL reset_outputs: some output nonzero, rdata=%h mem_addr=%h", rdata, mem_addr);
    end
    ram_clr = 1'b0;
    _reset = 1'b1;
    model_reset();
    idle(3);
  endtask

  task automatic test_reset_mid_wait();
    int first = -1;
    req = 1'b1; we = 1'b0; bank = 8'h01; addr = 18'h00005; be = 2'b11;
    @(negedge clk);
    n_cmp++;
    if (mem_en !== 1'b1) begin
      n_err++; $display("FAIL mid_wait_issue: mem_en got %b expected 1", mem_en);
    end
    @(negedge clk);
    _reset = 1'b0; req = 1'b0;
    #1;
    n_cmp++;
    if ({ack, unmapped, bank_err, mem_en, mem_we, mem_ref, rdata, mem_addr, mem_be, mem_wdata} !== '0) begin
      n_err++; $display("FAIL mid_wait_reset: outputs not cleared, rdata=%h mem_addr=%h", rdata, mem_addr);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (ack !== 1'b0) begin
        n_err++; $display("FAIL mid_wait_ack: ack got %b expected 0 during reset", ack);
      end
    end
    _reset = 1'b1;
    model_reset();
    for (int k = 0; k < REF_INT + 10; k++) begin
      idle(1);
      if (mem_ref && first < 0) first = cyc;
    end
    n_cmp++;
    if (first !== REF_INT + 1) begin
      n_err++; $display("FAIL first_refresh: mem_ref rose at cyc %0d expected %0d", first, REF_INT + 1);
    end
  endtask

  task automatic test_read();
    int t;
    do_txn(1'b1, 8'h04, 18'h00123, 2'b11, 16'hBEEF, t);
    idle(1);
    do_txn(1'b0, 8'h04, 18'h00123, 2'b11, 16'h0000, t);
    n_cmp++;
    if (rdata !== 16'hBEEF) begin
      n_err++; $display("FAIL read_hold: rdata got %h expected BEEF", rdata);
    end
  endtask

  task automatic test_write();
    int t;
    do_txn(1'b1, 8'h80, 18'h2A5A5, 2'b10, 16'h1234, t);
    idle(1);
  endtask

  task automatic test_unmapped();
    int t;
    do_txn(1'b0, 8'h00, 18'h00042, 2'b11, 16'h0000, t);
    n_cmp++;
    if (rdata !== 16'hFFFF) begin
      n_err++; $display("FAIL unmapped_hold: rdata got %h expected FFFF", rdata);
    end
    do_txn(1'b1, 8'h00, 18'h00001, 2'b11, 16'hCAFE, t);
  endtask

  task automatic test_multi_hot();
    int t;
    do_txn(1'b0, 8'h0A, 18'h00003, 2'b11, 16'h0000, t);
    do_txn(1'b1, 8'hC0, 18'h00004, 2'b01, 16'h7788, t);
    do_txn(1'b0, 8'h40, 18'h00004, 2'b11, 16'h0000, t);
  endtask

  task automatic test_refresh_collision();
    int t, w;
    bit found = 0;
    for (int k = 0; k < 3 * REF_INT && !found; k++) begin
      idle(1);
      if (cyc % REF_INT == 0 && free_edge <= cyc + 1) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_err++; $display("FAIL collision_align: no aligned idle slot found");
    end else begin
      w = cyc;
      do_txn(1'b0, 8'h01, 18'h00007, 2'b11, 16'h0000, t);
      n_cmp++;
      if (t !== w + REF_LEN + 1 + RD_LAT + 2) begin
        n_err++; $display("FAIL collision_latency: ack at %0d expected %0d", t, w + REF_LEN + 1 + RD_LAT + 2);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t;
    for (int k = 0; k < 8; k++)
      do_txn(1'($urandom), rand_bank(), 18'($urandom), 2'($urandom), 16'($urandom), t);
  endtask

  task automatic test_random();
    int t;
    for (int k = 0; k < 60; k++) begin
      do_txn(1'($urandom), rand_bank(), 18'($urandom), 2'($urandom), 16'($urandom), t);
      idle($urandom_range(0, 3));
    end
  endtask

  initial begin
    req = 1'b0; we = 1'b0; bank = '0; addr = '0; be = '0; wdata = '0;
    _reset = 1'b0; ram_clr = 1'b1;
    for (int i = 0; i < 64; i++) mdl[i] = init_word(i);
    test_reset();
    test_reset_mid_wait();
    test_read();
    test_write();
    test_unmapped();
    test_multi_hot();
    test_refresh_collision();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
